// File: rtl/cla_seq_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_adder_ctrl_pkg
// Purpose  : Shared definitions for the slice-sequential CLA adder: the
//            controller state encoding and the width of one adder slice.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cla_seq_adder_ctrl_pkg;

    // Width of the shared carry-lookahead slice.
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_cla4.sv
`default_nettype none
// ============================================================================
// Module   : clb4 / cla4
// Purpose  : clb4 is a 4-bit carry-lookahead block: it turns per-bit
//            generate/propagate terms and a carry-in into all four internal
//            carries without rippling. cla4 wraps it into a 4-bit adder.
// Ports    : clb4 - g[3:0], p[3:0], ci in; c[3:0] out (c[i] = carry out of bit i)
//            cla4 - a[3:0], b[3:0], ci in; s[3:0], co out
// Revision : 1.0 - initial release
// ============================================================================
module clb4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       ci,
    output logic [3:0] c
);

    // Fully expanded lookahead equations: every carry depends only on g, p, ci.
    assign c[0] = g[0] | (p[0] & ci);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

endmodule

module cla4
    import cla_seq_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [SLICE_W-1:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    clb4 u_clb4 (
        .g  (gen),
        .p  (prop),
        .ci (ci),
        .c  (carry)
    );

    // Bit i sums with the carry coming out of bit i-1 (ci for bit 0).
    assign s  = prop ^ {carry[SLICE_W-2:0], ci};
    assign co = carry[SLICE_W-1];

endmodule
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_adder_ctrl
// Purpose  : WIDTH-bit adder that time-shares one 4-bit CLA slice, one slice
//            per clock, LSB slice first, with the carry registered between
//            slices. Operands and results move over valid/ready handshakes.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready, a, b, ci   - operand handshake
//            out_valid/out_ready, s, co, ovf - result handshake
//            busy - high while an operation is being computed or held
// Revision : 1.0 - initial release
// ============================================================================
module cla_seq_adder_ctrl
    import cla_seq_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 32   // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             busy
);

    localparam int                NSLICE   = WIDTH / SLICE_W;
    localparam int                CNT_W    = $clog2(NSLICE);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NSLICE - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   s_r;       // working sum, filled slice by slice
    logic               carry_r;

    // Result registers: only updated when the last slice completes, so the
    // visible outputs keep the previous result during a new computation.
    logic [WIDTH-1:0]   s_res;
    logic               co_res;
    logic               ovf_res;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic [WIDTH-1:0]   s_merge;
    logic               last_slice;

    // ------------------------------------------------------------------
    // Shared slice: operand nibbles selected by the slice counter.
    // ------------------------------------------------------------------
    assign slice_a = a_r[cnt*SLICE_W +: SLICE_W];
    assign slice_b = b_r[cnt*SLICE_W +: SLICE_W];

    cla4 u_cla4 (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_r),
        .s  (slice_s),
        .co (slice_co)
    );

    // Working sum with the current slice already inserted; on the last slice
    // this is the complete result.
    always_comb begin
        s_merge = s_r;
        s_merge[cnt*SLICE_W +: SLICE_W] = slice_s;
    end

    assign last_slice = (cnt == LAST_CNT);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            s_res   <= '0;
            co_res  <= 1'b0;
            ovf_res <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= ci;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    s_r     <= s_merge;
                    carry_r <= slice_co;
                    if (last_slice) begin
                        cnt     <= '0;
                        s_res   <= s_merge;
                        co_res  <= slice_co;
                        // Same-sign operands whose sum flips sign.
                        ovf_res <= (a_r[WIDTH-1] == b_r[WIDTH-1])
                                && (slice_s[SLICE_W-1] != a_r[WIDTH-1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s   = s_res;
    assign co  = co_res;
    assign ovf = ovf_res;

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_seq_adder_ctrl
// Purpose  : Self-checking bench for cla_seq_adder_ctrl at WIDTH=32 and
//            WIDTH=8. Expected results come from a behavioural model and are
//            queued at operand accept; monitors pop and compare them when the
//            DUT presents a result, and also check result latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_seq_adder_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        in_valid32 = 1'b0, in_ready32, ci32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic        out_valid32, out_ready32 = 1'b1, co32, ovf32, busy32;
    // 8-bit instance
    logic        in_valid8 = 1'b0, in_ready8, ci8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        out_valid8, out_ready8 = 1'b1, co8, ovf8, busy8;

    cla_seq_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .ci(ci32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .s(s32), .co(co32), .ovf(ovf32), .busy(busy32)
    );

    cla_seq_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ci(ci8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .co(co8), .ovf(ovf8), .busy(busy8)
    );

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ovf;
        int          acc;
    } item_t;

    item_t q32[$];
    item_t q8[$];

    int cyc        = 0;
    int n_checks   = 0;
    int n_fail     = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic item_t model(input bit w8, input logic [31:0] a, input logic [31:0] b,
                                    input logic ci, input int acc);
        item_t       it;
        logic [32:0] sum;
        if (w8) begin
            sum    = {25'd0, a[7:0]} + {25'd0, b[7:0]} + {32'd0, ci};
            it.s   = {24'd0, sum[7:0]};
            it.co  = sum[8];
            it.ovf = (a[7] == b[7]) && (sum[7] != a[7]);
        end else begin
            sum    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            it.s   = sum[31:0];
            it.co  = sum[32];
            it.ovf = (a[31] == b[31]) && (sum[31] != a[31]);
        end
        it.acc = acc;
        return it;
    endfunction

    function automatic logic pick_ready();
        if (ready_mode == 1) return 1'($urandom_range(0, 1));
        if (ready_mode == 2) return 1'b0;
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Result monitors
    // ------------------------------------------------------------------
    bit pv32 = 0;
    always @(negedge clk) begin
        if (out_valid32) begin
            if (q32.size() == 0) begin
                check_eq("unexpected_valid32", 64'd1, 64'd0);
            end else begin
                if (!pv32) check_eq("latency32", 64'(cyc - q32[0].acc), 64'd8);
                check_eq("s32",   {32'd0, s32},   {32'd0, q32[0].s});
                check_eq("co32",  {63'd0, co32},  {63'd0, q32[0].co});
                check_eq("ovf32", {63'd0, ovf32}, {63'd0, q32[0].ovf});
            end
        end
        out_ready32 = pick_ready();
        if (out_valid32 && out_ready32 && q32.size() > 0) void'(q32.pop_front());
        pv32 = out_valid32 && !out_ready32;
    end

    bit pv8 = 0;
    always @(negedge clk) begin
        if (out_valid8) begin
            if (q8.size() == 0) begin
                check_eq("unexpected_valid8", 64'd1, 64'd0);
            end else begin
                if (!pv8) check_eq("latency8", 64'(cyc - q8[0].acc), 64'd2);
                check_eq("s8",   {56'd0, s8},    {32'd0, q8[0].s});
                check_eq("co8",  {63'd0, co8},   {63'd0, q8[0].co});
                check_eq("ovf8", {63'd0, ovf8},  {63'd0, q8[0].ovf});
            end
        end
        out_ready8 = pick_ready();
        if (out_valid8 && out_ready8 && q8.size() > 0) void'(q8.pop_front());
        pv8 = out_valid8 && !out_ready8;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input bit w8, input logic [31:0] a, input logic [31:0] b, input logic ci);
        bit ok;
        @(negedge clk);
        if (w8) begin a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; in_valid8 = 1'b1; end
        else    begin a32 = a;     b32 = b;     ci32 = ci; in_valid32 = 1'b1; end
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (w8 ? in_ready8 : in_ready32) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            in_valid8  = 1'b0;
            in_valid32 = 1'b0;
            return;
        end
        if (w8) q8.push_back(model(1'b1, a, b, ci, cyc + 1));
        else    q32.push_back(model(1'b0, a, b, ci, cyc + 1));
        @(posedge clk);
        #1;
        in_valid8  = 1'b0;
        in_valid32 = 1'b0;
        @(negedge clk);
        if (w8) check_eq("calc_ready_busy8",  {62'd0, in_ready8,  busy8},  64'd1);
        else    check_eq("calc_ready_busy32", {62'd0, in_ready32, busy32}, 64'd1);
    endtask

    task automatic drain(input bit w8);
        for (int k = 0; k < 500; k++) begin
            if ((w8 ? q8.size() : q32.size()) == 0) return;
            @(negedge clk);
        end
        check_eq(w8 ? "drain_timeout8" : "drain_timeout32", 64'd0, 64'd1);
    endtask

    task automatic check_idle32(input string tag);
        check_eq(tag, {32'd0, s32, in_ready32, out_valid32, co32, ovf32, busy32},
                 {32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit ok;
        // Power-on reset, checked before the first clock edge.
        #2 reset = 1'b1;
        #1;
        check_idle32("reset_state32");
        check_eq("reset_state8", {51'd0, s8, in_ready8, out_valid8, co8, ovf8, busy8},
                 {51'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed arithmetic cases.
        send(1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0);
        drain(1'b0);
        send(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drain(1'b0);
        send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drain(1'b0);
        send(1'b1, 32'h0000_00FF, 32'h0000_0000, 1'b1);
        drain(1'b1);
        send(1'b1, 32'h0000_007F, 32'h0000_0001, 1'b0);
        drain(1'b1);

        // Reset in the middle of a computation: result discarded.
        send(1'b0, 32'h1234_5678, 32'h0000_0001, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_idle32("reset_mid_calc");
        q32.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("no_result_after_reset", {63'd0, out_valid32}, 64'd0);

        // Backpressure: result held, second request ignored while in DONE.
        @(posedge clk);
        ready_mode = 2;
        send(1'b0, 32'h8000_0000, 32'h8000_0001, 1'b0);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid32) begin ok = 1; break; end
        end
        check_eq("bp_reach_done", {63'd0, ok}, 64'd1);
        repeat (5) begin
            @(negedge clk);
            a32 = 32'h0000_1111; b32 = 32'h0000_2222; ci32 = 1'b1; in_valid32 = 1'b1;
            check_eq("bp_hold", {61'd0, in_ready32, out_valid32, busy32}, 64'b011);
        end
        @(posedge clk);
        ready_mode = 0;
        send(1'b0, 32'h0000_1111, 32'h0000_2222, 1'b1);
        drain(1'b0);

        // Random operations with random sink backpressure.
        @(posedge clk);
        ready_mode = 1;
        for (int i = 0; i < 500; i++)
            send(1'b0, 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
        drain(1'b0);
        for (int i = 0; i < 500; i++)
            send(1'b1, 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
        drain(1'b1);
        @(posedge clk);
        ready_mode = 0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
